// File: rtl/td_i2c_pkg.sv
// td_i2c_pkg: shared FSM encoding, table length, retry limit and default device address for td_i2c_config
package td_i2c_pkg;
  typedef enum logic [2:0] {BUSCLR, IDLE, START, BIT, ACK, STOP, GAP, DONE} state_t;
  localparam int TABLE_LEN = 16;
  localparam logic [1:0] RETRY_MAX = 2'd3;
  localparam logic [7:0] DEF_DEV_ADDR = 8'h40;
endpackage

// File: rtl/td_i2c_rom.sv
// td_i2c_rom: ADV7181B power-up register table, {reg, data} per entry, selected combinationally by idx
module td_i2c_rom import td_i2c_pkg::*; (
  input  logic [7:0]  idx,
  output logic [15:0] data
);
  localparam logic [15:0] ROM [TABLE_LEN] = '{
    16'h1500, 16'h1741, 16'h3a16, 16'h5004, 16'hc305, 16'hc480, 16'h0e80, 16'h5020,
    16'h5218, 16'h58ed, 16'h77c5, 16'h7c93, 16'h7d00, 16'hd048, 16'hd5a0, 16'hd7ea
  };
  assign data = idx < 8'(TABLE_LEN) ? ROM[idx[3:0]] : 16'h0000;
endmodule

// File: rtl/td_i2c_config.sv
// td_i2c_config: I2C master writing the ADV7181B table after reset or iStart; define TD_I2C_CONFIG_RETRY_EN to retry NACKed entries
module td_i2c_config import td_i2c_pkg::*; #(
  parameter int CLK_KHZ = 50_000,
  parameter int SCL_KHZ = 100,
  parameter logic [7:0] DEV_ADDR = DEF_DEV_ADDR
) (
  input  logic       iClk50,
  input  logic       iReset_,
  input  logic       iStart,
  output logic       oI2C_SCLK,
  inout  wire        ioI2C_SDAT,
  output logic       oBusy,
  output logic       oDone,
  output logic       oAckErr,
  output logic [7:0] oIndex
);
  localparam int Q = CLK_KHZ / (4 * SCL_KHZ) > 1 ? CLK_KHZ / (4 * SCL_KHZ) : 1;
  localparam int DW = Q > 1 ? $clog2(Q) : 1;
`ifdef TD_I2C_CONFIG_RETRY_EN
  localparam logic [1:0] RETRIES = RETRY_MAX;
`else
  localparam logic [1:0] RETRIES = 2'd0;
`endif
  state_t state;
  logic [DW-1:0] div;
  logic tick, sda_oe, nacked;
  logic [1:0] q, byten, retries;
  logic [3:0] bitn;
  logic [15:0] entry;
  logic [7:0] cur;
  td_i2c_rom u_rom (.idx(oIndex), .data(entry));
  assign tick = div == DW'(Q - 1);
  assign cur = byten == 2'd0 ? DEV_ADDR : byten == 2'd1 ? entry[15:8] : entry[7:0];
  assign ioI2C_SDAT = sda_oe ? 1'b0 : 1'bz;
  // q is the quarter phase within a bit; bus outputs only move on tick
  always_ff @(posedge iClk50) begin
    if (!iReset_) begin
      div <= '0;
      state <= IDLE;
      q <= '0;
      bitn <= '0;
      byten <= '0;
      retries <= '0;
      sda_oe <= 1'b0;
      nacked <= 1'b0;
      oI2C_SCLK <= 1'b1;
      oBusy <= 1'b0;
      oDone <= 1'b0;
      oAckErr <= 1'b0;
      oIndex <= '0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      case (state)
        IDLE: begin
          oBusy <= 1'b1;
          state <= iStart ? START : BUSCLR;
        end
        DONE: if (iStart) begin
          oDone <= 1'b0;
          oAckErr <= 1'b0;
          oIndex <= '0;
          retries <= '0;
          oBusy <= 1'b1;
          state <= START;
        end
        default: if (tick) begin
          q <= q + 2'd1;
          case (state)
            BUSCLR: begin
              oI2C_SCLK <= q == 2'd1 || q == 2'd2;
              if (q == 2'd3) begin
                bitn <= bitn + 4'd1;
                if (bitn == 4'd8) state <= START;
              end
            end
            // coming out of BUSCLR SCL is low, so it is raised before SDA falls
            START: begin
              if (q == 2'd0) begin
                if (!oI2C_SCLK) begin
                  oI2C_SCLK <= 1'b1;
                  q <= '0;
                end else sda_oe <= 1'b1;
              end else begin
                oI2C_SCLK <= 1'b0;
                q <= '0;
                bitn <= '0;
                byten <= '0;
                nacked <= 1'b0;
                state <= BIT;
              end
            end
            BIT: begin
              oI2C_SCLK <= q == 2'd1 || q == 2'd2;
              if (q == 2'd0) sda_oe <= !cur[~bitn[2:0]];
              if (q == 2'd3) begin
                bitn <= bitn == 4'd7 ? 4'd0 : bitn + 4'd1;
                if (bitn == 4'd7) state <= ACK;
              end
            end
            ACK: begin
              oI2C_SCLK <= q == 2'd1 || q == 2'd2;
              if (q == 2'd0) sda_oe <= 1'b0;
              if (q == 2'd2) nacked <= ioI2C_SDAT;
              if (q == 2'd3) begin
                if (nacked || byten == 2'd2) state <= STOP;
                else begin
                  byten <= byten + 2'd1;
                  state <= BIT;
                end
              end
            end
            STOP: begin
              if (q == 2'd0) sda_oe <= 1'b1;
              if (q == 2'd1) oI2C_SCLK <= 1'b1;
              if (q == 2'd2) begin
                sda_oe <= 1'b0;
                q <= '0;
                state <= GAP;
              end
            end
            GAP: if (q == 2'd3) begin
              if (nacked && retries != RETRIES) begin
                retries <= retries + 2'd1;
                state <= START;
              end else begin
                retries <= '0;
                if (nacked) oAckErr <= 1'b1;
                if (oIndex == 8'(TABLE_LEN - 1)) begin
                  oBusy <= 1'b0;
                  oDone <= 1'b1;
                  state <= DONE;
                end else begin
                  oIndex <= oIndex + 8'd1;
                  state <= START;
                end
              end
            end
            default: ;
          endcase
        end
      endcase
    end
  end
endmodule

// File: tb/tb_td_i2c_config.sv
// tb_td_i2c_config: directed bench with an I2C slave/bus monitor for td_i2c_config (Q = 2 clocks)
module tb_td_i2c_config;
  localparam int CLK_KHZ = 800;
  localparam int SCL_KHZ = 100;
  localparam int Q = 2;
  localparam int TL = 16;
  localparam logic [7:0] NACK_REG = 8'h3a;
  localparam logic [15:0] TBL [TL] = '{
    16'h1500, 16'h1741, 16'h3a16, 16'h5004, 16'hc305, 16'hc480, 16'h0e80, 16'h5020,
    16'h5218, 16'h58ed, 16'h77c5, 16'h7c93, 16'h7d00, 16'hd048, 16'hd5a0, 16'hd7ea
  };
`ifdef TD_I2C_CONFIG_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n, start;
  logic scl, busy, done, ackerr;
  logic [7:0] idx;
  logic ack_drv = 1'b0;
  wire sda;
  pullup (sda);
  assign sda = ack_drv ? 1'b0 : 1'bz;
  always #5 clk = ~clk;
  td_i2c_config #(.CLK_KHZ(CLK_KHZ), .SCL_KHZ(SCL_KHZ), .DEV_ADDR(8'h40)) dut (
    .iClk50(clk), .iReset_(rst_n), .iStart(start), .oI2C_SCLK(scl), .ioI2C_SDAT(sda),
    .oBusy(busy), .oDone(done), .oAckErr(ackerr), .oIndex(idx)
  );
  int checks = 0, fails = 0;
  int cyc = 0, ntx = 0, starts = 0, pulses = 0, nrise = 0, nbits = 0, nbytes = 0, mode = 0;
  int t_rise [2];
  bit in_xfer = 1'b0, rose = 1'b0, nack_done = 1'b0;
  logic scl_p = 1'b1, sda_p = 1'b1;
  logic [7:0] shreg;
  logic [7:0] bytes [3];
  logic [7:0] ln [256], lb0 [256], lb1 [256], lb2 [256];
  int exp_q [$];
  // slave + monitor: logs every STOP-terminated transaction, ACKs per mode
  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst_n !== 1'b1) begin
      in_xfer = 1'b0; rose = 1'b0; nbits = 0; nbytes = 0; ack_drv = 1'b0;
      pulses = 0; nrise = 0; scl_p = 1'b1; sda_p = 1'b1;
    end else begin
      if (scl && scl_p && sda_p && !sda) begin
        in_xfer = 1'b1; nbits = 0; nbytes = 0; starts++;
      end else if (scl && scl_p && !sda_p && sda) begin
        if (in_xfer && ntx < 256) begin
          ln[ntx] = 8'(nbytes); lb0[ntx] = bytes[0]; lb1[ntx] = bytes[1]; lb2[ntx] = bytes[2];
          ntx++;
        end
        in_xfer = 1'b0;
      end else if (scl && !scl_p) begin
        if (!in_xfer) begin
          rose = 1'b1;
          if (nrise < 2) t_rise[nrise] = cyc;
          nrise++;
        end else begin
          if (nbits < 8) shreg = {shreg[6:0], sda};
          nbits++;
        end
      end else if (!scl && scl_p) begin
        if (!in_xfer && rose) begin
          pulses++; rose = 1'b0;
        end else if (in_xfer && nbits == 8 && nbytes < 3) begin
          bytes[nbytes] = shreg;
          if (mode == 2 || (mode == 1 && nbytes == 2 && bytes[1] == NACK_REG && !nack_done)) begin
            ack_drv = 1'b0;
            if (mode == 1) nack_done = 1'b1;
          end else ack_drv = 1'b1;
        end else if (in_xfer && nbits == 9) begin
          ack_drv = 1'b0; nbits = 0; nbytes++;
        end
      end
      scl_p = scl; sda_p = sda;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(input string tag);
    int i = 0;
    while (done !== 1'b1 && i < 15000) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_done"}, 32'(done), 1);
  endtask
  task automatic wait_first_start(input string tag);
    int i = 0;
    while (starts == 0 && i < 2000) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_busclr_pulses"}, pulses, 9);
  endtask
  task automatic run_check(input string tag, input int base);
    chk({tag, "_count"}, ntx - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < ntx; i++)
      chk($sformatf("%s_tx%0d", tag, i), {ln[base+i], lb0[base+i], lb1[base+i], lb2[base+i]},
          {8'd3, 8'h40, TBL[exp_q[i]]});
  endtask
  initial begin
    int base, s, i;
    rst_n = 1'b0; start = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_scl", 32'(scl), 1);
    chk("rst_sda", 32'(sda), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ackerr", 32'(ackerr), 0);
    chk("rst_index", 32'(idx), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("autorun_busy", 32'(busy), 1);
    starts = 0;
    wait_first_start("run0");
    chk("scl_period", t_rise[1] - t_rise[0], 4 * Q);
    wait_done("run0");
    exp_q.delete();
    for (int k = 0; k < TL; k++) exp_q.push_back(k);
    run_check("run0", 0);
    chk("run0_ackerr", 32'(ackerr), 0);
    chk("run0_busy", 32'(busy), 0);
    chk("run0_index", 32'(idx), TL - 1);
    base = ntx; s = starts;
    pulse_start();
    chk("restart_done", 32'(done), 0);
    chk("restart_index", 32'(idx), 0);
    chk("restart_busy", 32'(busy), 1);
    i = 0;
    while (starts == s && i < Q + 2) begin
      @(negedge clk);
      i++;
    end
    chk("restart_latency", 32'(starts > s), 1);
    i = 0;
    while (ntx < base + 3 && i < 5000) begin
      @(negedge clk);
      i++;
    end
    pulse_start();
    chk("midrun_index", 32'(idx), 2);
    chk("midrun_busy", 32'(busy), 1);
    wait_done("run1");
    run_check("run1", base);
    chk("run1_ackerr", 32'(ackerr), 0);
    mode = 1; nack_done = 1'b0; base = ntx;
    pulse_start();
    wait_done("nack1");
    exp_q.delete();
    for (int k = 0; k < TL; k++) begin
      exp_q.push_back(k);
      if (k == 2 && RETRY) exp_q.push_back(k);
    end
    run_check("nack1", base);
    chk("nack1_ackerr", 32'(ackerr), RETRY ? 0 : 1);
    mode = 2; base = ntx;
    pulse_start();
    chk("nackall_ackerr_cleared", 32'(ackerr), 0);
    wait_done("nackall");
    chk("nackall_count", ntx - base, RETRY ? 4 * TL : TL);
    chk("nackall_first", {ln[base], lb0[base]}, {8'd1, 8'h40});
    chk("nackall_last", {ln[ntx-1], lb0[ntx-1]}, {8'd1, 8'h40});
    chk("nackall_ackerr", 32'(ackerr), 1);
    chk("nackall_busy", 32'(busy), 0);
    mode = 0;
    pulse_start();
    chk("rerun_ackerr_cleared", 32'(ackerr), 0);
    i = 0;
    while (!(in_xfer && nbytes == 1 && nbits == 4 && scl === 1'b0 && sda === 1'b0) && i < 2000) begin
      @(negedge clk);
      i++;
    end
    chk("midbit_reached", 32'(sda), 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_scl", 32'(scl), 1);
    chk("midrst_sda", 32'(sda), 1);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_index", 32'(idx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    base = ntx; starts = 0;
    wait_first_start("rerst");
    wait_done("rerst");
    exp_q.delete();
    for (int k = 0; k < TL; k++) exp_q.push_back(k);
    run_check("rerst", base);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/td_i2c_config.md
TD_I2C_CONFIG -- requirements
Module: td_i2c_config

Interface
REQ-001 Parameter CLK_KHZ, 50_000, system clock frequency in kHz; the module SHALL use it for SCL timing.
REQ-002 Parameter SCL_KHZ, 100, target SCL frequency in kHz; the module SHALL use it for SCL timing.
REQ-003 Parameter DEV_ADDR, 8'h40, I2C write address of the TV decoder; the module SHALL send it as byte 0 of every transaction.
REQ-004 iClk50  input  1  system clock; one clock; the module SHALL have no other clock.
REQ-005 iReset_  input  1  reset, synchronous, active-low.
REQ-006 iStart  input  1  one-cycle pulse that SHALL re-run the whole table.
REQ-007 oI2C_SCLK  output  1  I2C clock; the module SHALL drive it push-pull.
REQ-008 ioI2C_SDAT  inout  1  I2C data; the module SHALL only drive 0 or high-Z (open-drain).
REQ-009 oBusy  output  1  SHALL be high while a table run is in progress.
REQ-010 oDone  output  1  SHALL be high from run completion until the next run starts.
REQ-011 oAckErr  output  1  sticky flag; SHALL be set when any entry is finally NACKed.
REQ-012 oIndex  output  8  SHALL show the current table entry index.

Function
REQ-013 Quarter tick SHALL occur every Q = CLK_KHZ/(4*SCL_KHZ) cycles (125 at defaults); bus events SHALL change only on ticks.
REQ-014 FSM states SHALL be BUSCLR, IDLE, START, BIT, ACK, STOP, GAP, DONE.
REQ-015 BUSCLR: with SDA released, the module SHALL issue 9 SCL pulses, then enter START.
REQ-016 START: SDA SHALL fall while SCL is high, then SCL SHALL go low one quarter later.
REQ-017 Each bit SHALL take 4 quarters: Q0 SCL low and SDA set (MSB first), Q1 SCL rises, Q2 SCL high, Q3 SCL falls.
REQ-018 Each transaction SHALL be 3 bytes: DEV_ADDR, register, data; each byte SHALL be followed by an ACK bit with SDA released.
REQ-019 ACK SHALL be sampled at Q2 of the 9th bit; SDA=1 is a NACK and SHALL abort the transaction to STOP.
REQ-020 STOP: SDA SHALL be low while SCL is low, then SCL SHALL rise, then SDA SHALL be released one quarter later.
REQ-021 GAP SHALL hold the bus idle for 4 quarters, then advance oIndex.
REQ-022 After the last entry (TABLE_LEN-1) the FSM SHALL enter DONE: oBusy=0, oDone=1.
REQ-023 iStart in DONE or IDLE SHALL clear oDone and oAckErr, set oIndex=0, and enter START on the next tick.
REQ-024 iStart while oBusy=1 SHALL be ignored.
REQ-025 Divider and bit counters SHALL NOT wrap past their terminal counts (Q-1, bit 8, byte 2).

Reset
REQ-026 While iReset_=0, outputs SHALL be: oI2C_SCLK=1, SDA high-Z, oBusy=0, oDone=0, oAckErr=0, oIndex=0, divider=0.
REQ-027 Reset asserted mid-transaction SHALL release the bus on the next iClk50 edge with no STOP.
REQ-028 After iReset_ rises the module SHALL enter BUSCLR with oBusy=1, i.e. auto-run the table.

Configuration
REQ-029 Macro TD_I2C_CONFIG_RETRY_EN SHALL select NACK handling.
REQ-030 With TD_I2C_CONFIG_RETRY_EN defined, a NACKed entry SHALL be retried after GAP, at most 3 retries; only a 4th NACK sets oAckErr and skips the entry.
REQ-031 Without TD_I2C_CONFIG_RETRY_EN, the first NACK SHALL set oAckErr and skip the entry.

Structure
REQ-032 Package td_i2c_pkg SHALL hold the FSM state encoding, TABLE_LEN, retry limit, and the default DEV_ADDR.
REQ-033 Sub-module td_i2c_rom SHALL map oIndex to a 16-bit {reg, data} value combinationally and hold the ADV7181B table.

Verification
REQ-034 Reset release at defaults with an ACKing slave model -> 9 BUSCLR pulses, then START; SCL period = 500 cycles; first bytes on bus = 0x40, rom[0].reg, rom[0].data.
REQ-035 Full run with all ACKs -> TABLE_LEN transactions in order, then oDone=1, oAckErr=0, oBusy=0.
REQ-036 Slave NACKs entry 2 once, RETRY_EN defined -> entry 2 sent twice, oAckErr=0; RETRY_EN undefined -> entry 2 sent once, oAckErr=1, entry 3 follows.
REQ-037 Slave NACKs every byte, RETRY_EN defined -> each entry sent 4 times, oAckErr=1, run still completes with oDone=1.
REQ-038 iStart pulsed mid-run -> ignored; iStart in DONE -> oDone=0, oAckErr cleared, oIndex=0, new START within Q cycles.
REQ-039 iReset_ low during bit 5 of byte 1 -> next edge gives SCL=1 and SDA=Z; after release, BUSCLR then entry 0 is sent again.
